// File: rtl/sequential_alu_arbiter.sv
// sequential_alu_arbiter: round-robin arbiter sharing one sequential ALU
// between NUM_REQ requesters. Latches the winner's opcode/operands, holds
// one-hot op strobes until the ALU accepts, then returns result, overflow
// and a one-cycle done pulse to the winner.
// Optional macro ALU_TIMEOUT_EN: aborts an operation after TIMEOUT BUSY
// cycles without accept (o_q=0, o_ovf=1, o_timeout=1).
module sequential_alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [2*NUM_REQ-1:0]          i_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_b,
  output logic [NUM_REQ-1:0]            o_done,
  output logic [DATA_WIDTH-1:0]         o_q,
  output logic                          o_ovf,
  output logic                          o_timeout,
  output logic                          o_busy,
  output logic [DATA_WIDTH-1:0]         o_alu_a,
  output logic [DATA_WIDTH-1:0]         o_alu_b,
  output logic                          o_alu_add,
  output logic                          o_alu_sub,
  output logic                          o_alu_mul,
  output logic                          o_alu_div,
  input  logic [DATA_WIDTH-1:0]         i_alu_q,
  input  logic                          i_alu_ovf,
  input  logic                          i_alu_accept
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grant;
  logic [3:0]      strobe;   // {div, mul, sub, add}
  logic [PW-1:0]   win;
  logic            win_found;
  logic [PW-1:0]   next_ptr;
  logic [1:0]      sel_op;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;

  assign o_alu_add = strobe[0];
  assign o_alu_sub = strobe[1];
  assign o_alu_mul = strobe[2];
  assign o_alu_div = strobe[3];

  // Round-robin search: first set request starting at ptr, wrapping.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      automatic int unsigned idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && i_req[idx]) begin
        win_found = 1'b1;
        win       = PW'(idx);
      end
    end
  end

  // Winner's operands/opcode and the pointer value following the grant.
  always_comb begin
    sel_op   = i_op[2*win +: 2];
    sel_a    = i_a[win*DATA_WIDTH +: DATA_WIDTH];
    sel_b    = i_b[win*DATA_WIDTH +: DATA_WIDTH];
    next_ptr = (grant == PW'(NUM_REQ-1)) ? '0 : grant + 1'b1;
  end

`ifdef ALU_TIMEOUT_EN
  logic [7:0] tcnt;
`else
  assign o_timeout = 1'b0;
`endif

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      strobe  <= '0;
      o_done  <= '0;
      o_q     <= '0;
      o_ovf   <= 1'b0;
      o_busy  <= 1'b0;
      o_alu_a <= '0;
      o_alu_b <= '0;
`ifdef ALU_TIMEOUT_EN
      tcnt      <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            o_alu_a <= sel_a;
            o_alu_b <= sel_b;
            strobe  <= 4'b0001 << sel_op;
            grant   <= win;
            o_busy  <= 1'b1;
            state   <= BUSY;
`ifdef ALU_TIMEOUT_EN
            tcnt    <= '0;
`endif
          end
        end
        BUSY: begin
          if (i_alu_accept) begin
            o_q    <= i_alu_q;
            o_ovf  <= i_alu_ovf;
            strobe <= '0;
            o_done <= NUM_REQ'(1) << grant;
            ptr    <= next_ptr;
            state  <= RESP;
`ifdef ALU_TIMEOUT_EN
            o_timeout <= 1'b0;
          end else if (tcnt == 8'(TIMEOUT - 1)) begin
            // Counter value TIMEOUT-1 marks the TIMEOUT-th BUSY cycle.
            o_q       <= '0;
            o_ovf     <= 1'b1;
            o_timeout <= 1'b1;
            strobe    <= '0;
            o_done    <= NUM_REQ'(1) << grant;
            ptr       <= next_ptr;
            state     <= RESP;
          end else begin
            tcnt <= tcnt + 8'd1;
`endif
          end
        end
        RESP: begin
          o_done <= '0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sequential_alu_arbiter.md
Name: sequential_alu_arbiter

Overview:
- Round-robin arbiter that shares one sequential_alu instance between NUM_REQ requesters.
- Latches the winning requester's opcode and operands, then drives the ALU's one-hot op strobes until the ALU accepts.
- Returns the result, overflow flag and a one-cycle done pulse to the winning requester.
- Sits between the requester blocks and the single ALU instance.

Parameters:
- DATA_WIDTH, 32, operand and result width; must match the ALU.
- NUM_REQ, 4, number of requesters; range 2..8.
- TIMEOUT, 255, maximum BUSY cycles before abort; used only with ALU_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_nrst  in  1  reset, synchronous, active-low.
- i_req  in  NUM_REQ  per-requester request level.
- i_op  in  2*NUM_REQ  per-requester opcode: 00 add, 01 sub, 10 mul, 11 div.
- i_a  in  NUM_REQ*DATA_WIDTH  per-requester operand A.
- i_b  in  NUM_REQ*DATA_WIDTH  per-requester operand B.
- o_done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- o_q  out  DATA_WIDTH  result; valid while o_done is nonzero.
- o_ovf  out  1  overflow flag; valid while o_done is nonzero.
- o_timeout  out  1  abort flag; valid while o_done is nonzero.
- o_busy  out  1  high when state is not IDLE.
- o_alu_a  out  DATA_WIDTH  operand A to ALU.
- o_alu_b  out  DATA_WIDTH  operand B to ALU.
- o_alu_add, o_alu_sub, o_alu_mul, o_alu_div  out  1 each  one-hot ALU op strobes.
- i_alu_q  in  DATA_WIDTH  ALU result.
- i_alu_ovf  in  1  ALU overflow.
- i_alu_accept  in  1  ALU completion; result is valid in the same cycle.

Behaviour:
- Reset: i_nrst low at a rising edge sets state IDLE, priority pointer 0, and all outputs 0 (o_done, o_q, o_ovf, o_timeout, o_busy, o_alu_*). All outputs are registered.
- Reset mid-operation: the operation is abandoned and no o_done is issued. The ALU sees its op strobes fall; the ALU's own reset is the integrator's responsibility.
- State machine: IDLE, BUSY, RESP.
- IDLE, no request: if i_req is all zero, stay in IDLE.
- IDLE, request present: choose the winner g by round-robin. Search starts at the pointer index and wraps modulo NUM_REQ; the first set bit wins.
  - Latch i_a[g], i_b[g] into o_alu_a/o_alu_b.
  - Decode i_op[g] to exactly one o_alu_* strobe.
  - Store g, go to BUSY.
  - Request-to-strobe latency is 1 cycle.
- BUSY:
  - o_alu_a, o_alu_b and the strobe are held constant.
  - Requester inputs are ignored, including the winner dropping i_req; the operation still completes.
  - On i_alu_accept=1: register i_alu_q into o_q and i_alu_ovf into o_ovf, clear all strobes, set o_done[g]=1, set pointer to (g+1) mod NUM_REQ, go to RESP.
- RESP:
  - o_done is high for exactly this one cycle; then clear o_done and go to IDLE.
  - o_q and o_ovf hold their value until the next RESP.
- Requester contract: hold i_req, i_op and operands stable from assertion until o_done. Deassert i_req in the o_done cycle. A request still high in IDLE is treated as a new request.
- Strobes are guaranteed low for at least 2 cycles between operations (RESP and IDLE), so the ALU never sees a stale strobe.
- Throughput: ALU latency + 2 cycles per operation.
- Simultaneous requests: exactly one grant per arbitration. Starvation-free: a continuously asserted request is served within NUM_REQ operations.
- i_alu_accept outside BUSY is ignored.
- o_busy = (state != IDLE).

Optional Feature:
- ALU_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering BUSY and increments every BUSY cycle.
  - If it reaches TIMEOUT without i_alu_accept: clear strobes, set o_q=0, o_ovf=1, o_timeout=1, pulse o_done[g], advance pointer, go to RESP.
  - If accept and timeout coincide, accept wins and o_timeout=0.
- ALU_TIMEOUT_EN undefined: no counter; o_timeout is tied 0; BUSY waits indefinitely.

Test Plan:
- Reset, then i_req=0001, op 00 (add), a=1, b=1, ALU model accepts after 3 cycles -> o_alu_add high 1 cycle after request; o_done=0001 with o_q=2, o_ovf=0; o_busy falls the next cycle.
- i_req=1111 held continuously, each requester issues mul 7*-7 -> grants in order 0,1,2,3,0; every o_done carries o_q=0xFFFFFFCF (-49), o_ovf=0.
- Requester 2 issues sub 0x80000000-1 -> o_alu_sub asserted; o_done=0100 with o_ovf=1; no other strobe is ever high.
- Requester 1 drops i_req mid-BUSY -> o_done=0010 is still pulsed with the result; the pointer advances to 2.
- Reset asserted during BUSY -> the next cycle has all outputs 0, state IDLE, and no o_done ever issued for the aborted operation.
- With ALU_TIMEOUT_EN, TIMEOUT=10, ALU never accepts -> after 10 BUSY cycles o_done pulses with o_timeout=1, o_ovf=1, o_q=0. Without the macro, o_busy stays high.
